ring_johnson_counter: RTL and testbench
=======================================

Name: ring_johnson_counter

Overview:
- Parametrised N-bit shift-register counter, a successor to the fixed 4-bit ring counter.
- Runtime-selectable ring or Johnson (twisted-ring) mode and left or right shift direction.
- Adds count enable, synchronous parallel load, a wrap pulse and an illegal-state flag.
- Used as a one-hot or thermometer sequencer driving phase selects and timing strobes.

Parameters:
- N, 4, counter width in bits; legal range N >= 2.
- INIT, 1 (i.e. 0...01), ring-mode start pattern; must be one-hot.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- en  input  1  shift enable.
- mode  input  1  0 = ring, 1 = Johnson.
- dir  input  1  0 = shift left (towards MSB), 1 = shift right (towards LSB).
- load  input  1  synchronous parallel load strobe.
- load_val  input  N  value written to q on load.
- q  output  N  counter state, registered.
- wrap  output  1  registered; high for one cycle when a shift returns q to the start pattern.
- illegal  output  1  combinational from q; q is not a legal state for the current mode.

Behaviour:
- Priority at each rising clk edge: rst==0 > load > en > hold.
- Start pattern S: INIT when mode=0; all zeros when mode=1.
- Reset (rst==0): q <= S using the mode sampled that edge; wrap <= 0.
- Load: q <= load_val, stored unconditionally even if illegal; wrap <= 0.
- Hold (en=0, load=0): q holds its value; wrap <= 0.
- Ring shift, left: q <= {q[N-2:0], q[N-1]}.
- Ring shift, right: q <= {q[0], q[N-1:1]}.
- Johnson shift, left: q <= {q[N-2:0], ~q[N-1]}.
- Johnson shift, right: q <= {~q[0], q[N-1:1]}.
- wrap:
  - On a shift edge, wrap <= 1 iff the next q equals S; otherwise wrap <= 0.
  - wrap is never set by load or reset, even if load_val equals S.
- Sequence period from S with en held high: N cycles in ring mode, 2N cycles in Johnson mode. Direction does not change the period.
- Legality:
  - Ring: q is one-hot.
  - Johnson: count of i in [0, N-2] with q[i] != q[i+1] is <= 1 (thermometer form).
  - illegal = !legal(q, mode). It updates combinationally when mode changes.
- Mode or dir change mid-run:
  - Takes effect on the next shift; no implicit reset.
  - The current q may become illegal under the new mode and is flagged via illegal.
- Reset mid-operation overrides load and en in the same cycle.
- Latency: q and wrap change exactly one clock after the qualifying input sample; there is no pipeline.

Optional Feature:
- Macro: RING_SELF_CORRECT_EN.
- Defined:
  - On an en edge (load=0) where illegal==1, q <= S instead of shifting; wrap <= 0.
  - Load still stores illegal values; correction occurs on the next enabled edge.
- Undefined:
  - Illegal states shift by the normal rules and are never corrected. Example: ring 0000 stays 0000; ring 0101 alternates 1010/0101.
  - illegal still reports the condition.

Test Plan:
1. N=4, INIT=0001, reset 1 cycle, then mode=0, dir=0, en=1 -> q 0001, 0010, 0100, 1000, 0001; wrap=1 only in the cycle q returns to 0001; illegal=0 throughout.
2. Reset, then mode=1, dir=0, en=1 -> q 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap=1 only on the 8th shift.
3. Reset, then mode=0, dir=1, en=1 -> q 0001, 1000, 0100, 0010, 0001, wrap on the 4th shift. Then en=0 for 3 cycles -> q holds, wrap=0.
4. mode=0, load=1, load_val=0101 -> q=0101, illegal=1, wrap=0. Next en edge: without macro q=1010; with RING_SELF_CORRECT_EN q=0001 and wrap=0.
5. rst=0 with load=1, en=1 asserted -> q=0001 (mode=0) or 0000 (mode=1), wrap=0. Also: load=1 and en=1 with load_val=0001 -> q=0001, wrap=0 (load wins over en).
6. Johnson run stopped at q=0111, then mode switched to 0 -> illegal=1 immediately. Without macro the next left shift gives 1110; with macro it gives 0001.

Source files
------------

// File: rtl/ring_johnson_counter.sv
// rtl/ring_johnson_counter.sv - N-bit ring/Johnson shift counter with load, wrap and illegal flag
// Optional macro RING_SELF_CORRECT_EN: an enabled shift from an illegal state restarts at the start pattern.
module ring_johnson_counter #(
  parameter int           N    = 4,
  parameter logic [N-1:0] INIT = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         wrap,
  output logic         illegal
);

  logic [N-1:0] r_q;
  logic         r_wrap;

  logic [N-1:0] w_start;
  logic [N-1:0] w_shift;
  logic [N-1:0] w_next;
  logic         w_next_wrap;
  logic [N-2:0] w_edges;
  logic         w_ring_ok;
  logic         w_john_ok;
  logic         w_illegal;

  assign w_start = mode ? '0 : INIT;

  // Thermometer form has at most one boundary between adjacent bits.
  assign w_edges   = r_q[N-2:0] ^ r_q[N-1:1];
  assign w_john_ok = ((w_edges & (w_edges - (N-1)'(1))) == '0);
  assign w_ring_ok = (r_q != '0) && ((r_q & (r_q - N'(1))) == '0);
  assign w_illegal = mode ? !w_john_ok : !w_ring_ok;

  always_comb begin
    w_shift = r_q;
    case ({mode, dir})
      2'b00:   w_shift = {r_q[N-2:0], r_q[N-1]};
      2'b01:   w_shift = {r_q[0], r_q[N-1:1]};
      2'b10:   w_shift = {r_q[N-2:0], ~r_q[N-1]};
      default: w_shift = {~r_q[0], r_q[N-1:1]};
    endcase
  end

  always_comb begin
    w_next      = w_shift;
    w_next_wrap = (w_shift == w_start);
`ifdef RING_SELF_CORRECT_EN
    if (w_illegal) begin
      w_next      = w_start;
      w_next_wrap = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q    <= w_start;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= load_val;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= w_next;
      r_wrap <= w_next_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q       = r_q;
  assign wrap    = r_wrap;
  assign illegal = w_illegal;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb/tb_ring_johnson_counter.sv - table-driven scoreboard bench for ring_johnson_counter (N=4, INIT=0001)
module tb_ring_johnson_counter;

  localparam int N = 4;

  typedef struct {
    string      tag;
    logic       rst;
    logic       load;
    logic       en;
    logic       mode;
    logic       dir;
    logic [N-1:0] lv;
    logic [N-1:0] eq;
    logic       ew;
    logic       ei;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] q;
  logic         wrap;
  logic         illegal;

  int n_vec = 0;
  int n_bad = 0;

  vec_t vecs[$];
  vec_t sb[$];

  ring_johnson_counter #(.N(N), .INIT(4'b0001)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .q(q), .wrap(wrap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic add(input string t, input logic r, input logic l, input logic e,
                     input logic m, input logic d, input logic [N-1:0] lv,
                     input logic [N-1:0] eq, input logic ew, input logic ei);
    vec_t v;
    v.tag = t; v.rst = r; v.load = l; v.en = e; v.mode = m; v.dir = d;
    v.lv = lv; v.eq = eq; v.ew = ew; v.ei = ei;
    vecs.push_back(v);
  endtask

  task automatic check(input string t, input logic [N-1:0] aq, input logic [N-1:0] eq,
                       input logic aw, input logic ew, input logic ai, input logic ei);
    n_vec++;
    if (aq !== eq || aw !== ew || ai !== ei) begin
      n_bad++;
      $display("FAIL %s: got q=%b wrap=%b illegal=%b, want q=%b wrap=%b illegal=%b",
               t, aq, aw, ai, eq, ew, ei);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; load = v.load; en = v.en; mode = v.mode; dir = v.dir; load_val = v.lv;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, q, e.eq, wrap, e.ew, illegal, e.ei);
  endtask

  initial begin
    // ring left
    add("rst_ring",   0,0,0,0,0,4'b0000, 4'b0001,0,0);
    add("rl1",        1,0,1,0,0,4'b0000, 4'b0010,0,0);
    add("rl2",        1,0,1,0,0,4'b0000, 4'b0100,0,0);
    add("rl3",        1,0,1,0,0,4'b0000, 4'b1000,0,0);
    add("rl4_wrap",   1,0,1,0,0,4'b0000, 4'b0001,1,0);
    add("rl5",        1,0,1,0,0,4'b0000, 4'b0010,0,0);
    // Johnson left
    add("rst_john",   0,0,0,1,0,4'b0000, 4'b0000,0,0);
    add("jl1",        1,0,1,1,0,4'b0000, 4'b0001,0,0);
    add("jl2",        1,0,1,1,0,4'b0000, 4'b0011,0,0);
    add("jl3",        1,0,1,1,0,4'b0000, 4'b0111,0,0);
    add("jl4",        1,0,1,1,0,4'b0000, 4'b1111,0,0);
    add("jl5",        1,0,1,1,0,4'b0000, 4'b1110,0,0);
    add("jl6",        1,0,1,1,0,4'b0000, 4'b1100,0,0);
    add("jl7",        1,0,1,1,0,4'b0000, 4'b1000,0,0);
    add("jl8_wrap",   1,0,1,1,0,4'b0000, 4'b0000,1,0);
    add("jl9",        1,0,1,1,0,4'b0000, 4'b0001,0,0);
    // Johnson right
    add("rst_john2",  0,0,0,1,1,4'b0000, 4'b0000,0,0);
    add("jr1",        1,0,1,1,1,4'b0000, 4'b1000,0,0);
    add("jr2",        1,0,1,1,1,4'b0000, 4'b1100,0,0);
    add("jr3",        1,0,1,1,1,4'b0000, 4'b1110,0,0);
    add("jr4",        1,0,1,1,1,4'b0000, 4'b1111,0,0);
    add("jr5",        1,0,1,1,1,4'b0000, 4'b0111,0,0);
    add("jr6",        1,0,1,1,1,4'b0000, 4'b0011,0,0);
    add("jr7",        1,0,1,1,1,4'b0000, 4'b0001,0,0);
    add("jr8_wrap",   1,0,1,1,1,4'b0000, 4'b0000,1,0);
    // ring right then hold
    add("rst_ring2",  0,0,0,0,1,4'b0000, 4'b0001,0,0);
    add("rr1",        1,0,1,0,1,4'b0000, 4'b1000,0,0);
    add("rr2",        1,0,1,0,1,4'b0000, 4'b0100,0,0);
    add("rr3",        1,0,1,0,1,4'b0000, 4'b0010,0,0);
    add("rr4_wrap",   1,0,1,0,1,4'b0000, 4'b0001,1,0);
    add("hold1",      1,0,0,0,1,4'b0000, 4'b0001,0,0);
    add("hold2",      1,0,0,0,1,4'b0000, 4'b0001,0,0);
    add("hold3",      1,0,0,0,1,4'b0000, 4'b0001,0,0);
    // illegal loads
    add("ld_0101",    1,1,0,0,0,4'b0101, 4'b0101,0,1);
`ifdef RING_SELF_CORRECT_EN
    add("fix_0101",   1,0,1,0,0,4'b0000, 4'b0001,0,0);
    add("after_fix",  1,0,1,0,0,4'b0000, 4'b0010,0,0);
`else
    add("sh_0101",    1,0,1,0,0,4'b0000, 4'b1010,0,1);
    add("sh_1010",    1,0,1,0,0,4'b0000, 4'b0101,0,1);
`endif
    add("ld_0000",    1,1,0,0,0,4'b0000, 4'b0000,0,1);
`ifdef RING_SELF_CORRECT_EN
    add("fix_0000",   1,0,1,0,0,4'b0000, 4'b0001,0,0);
`else
    add("sh_0000",    1,0,1,0,0,4'b0000, 4'b0000,0,1);
`endif
    add("ld_j0101",   1,1,0,1,0,4'b0101, 4'b0101,0,1);
    add("hold_r0101", 1,0,0,0,0,4'b0000, 4'b0101,0,1);
    add("ld_j1000",   1,1,0,1,0,4'b1000, 4'b1000,0,0);
    add("hold_r1000", 1,0,0,0,0,4'b0000, 4'b1000,0,0);
    // priorities
    add("rst_over_r", 0,1,1,0,0,4'b1111, 4'b0001,0,0);
    add("rst_over_j", 0,1,1,1,0,4'b1111, 4'b0000,0,0);
    add("ld_over_en", 1,1,1,0,0,4'b0001, 4'b0001,0,0);
    add("ld_s_again", 1,1,1,0,0,4'b0001, 4'b0001,0,0);
    // mode switch mid-run
    add("rst_j3",     0,0,0,1,0,4'b0000, 4'b0000,0,0);
    add("j3_1",       1,0,1,1,0,4'b0000, 4'b0001,0,0);
    add("j3_2",       1,0,1,1,0,4'b0000, 4'b0011,0,0);
    add("j3_3",       1,0,1,1,0,4'b0000, 4'b0111,0,0);
    add("sw_ring",    1,0,0,0,0,4'b0000, 4'b0111,0,1);
`ifdef RING_SELF_CORRECT_EN
    add("sw_shift",   1,0,1,0,0,4'b0000, 4'b0001,0,0);
`else
    add("sw_shift",   1,0,1,0,0,4'b0000, 4'b1110,0,1);
`endif

    foreach (vecs[i]) apply(vecs[i]);

    // Combinational illegal on a mode flip with no clock edge in between.
    begin
      vec_t v;
      v.tag = "h_rst"; v.rst = 0; v.load = 0; v.en = 0; v.mode = 1; v.dir = 0;
      v.lv = '0; v.eq = 4'b0000; v.ew = 0; v.ei = 0;
      apply(v);
      v.rst = 1; v.en = 1;
      v.tag = "h_j1"; v.eq = 4'b0001; apply(v);
      v.tag = "h_j2"; v.eq = 4'b0011; apply(v);
      @(negedge clk);
      en = 0;
      mode = 0;
      #1;
      check("h_flip_ring", q, 4'b0011, wrap, 1'b0, illegal, 1'b1);
      mode = 1;
      #1;
      check("h_flip_back", q, 4'b0011, wrap, 1'b0, illegal, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
